// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel row readout receiver.
// Optional Gray-to-binary decode of pixel codes is selected with PIXEL_RX_GRAY_DECODE_EN.
package pixel_pkg;

  localparam int PIX_DATA_W     = 8;
  localparam int PIX_N_ROWS     = 2;
  localparam int PIX_N_COLS     = 2;
  localparam int PIX_FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic [PIX_DATA_W-1:0] data;
    logic                  sof;
    logic                  eol;
    logic                  eof;
  } pix_entry_t;

  // Zero-extended input keeps this width-agnostic: leading zeros leave the prefix XOR unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/pixel_rx_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible combinationally whenever non-empty.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module pixel_rx_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] dat_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] dat_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dat_o   = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= dat_i;
  end

endmodule

// File: rtl/pixel_readout_rx.sv
// Row readout receiver: latches a row per strobe and serializes it into a tagged pixel stream.
// Latency row_valid -> pix_valid is 2 cycles; full FIFO stalls serialization. Gray decode: PIXEL_RX_GRAY_DECODE_EN.
module pixel_readout_rx
  import pixel_pkg::*;
#(
  parameter int N_ROWS     = PIX_N_ROWS,
  parameter int N_COLS     = PIX_N_COLS,
  parameter int DATA_W     = PIX_DATA_W,
  parameter int FIFO_DEPTH = PIX_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       row_valid,
  input  logic [$clog2(N_ROWS)-1:0]  row_idx,
  input  logic [N_COLS*DATA_W-1:0]   row_data,
  output logic                       rx_busy,
  input  logic                       clr_ovf,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [DATA_W-1:0]          pix_data,
  output logic                       pix_sof,
  output logic                       pix_eol,
  output logic                       pix_eof,
  output logic [15:0]                frame_cnt,
  output logic                       ovf_err
);

  localparam int IW = $clog2(N_ROWS);
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int EW = DATA_W + 3;

  rx_state_t               state_q, state_d;
  logic [N_COLS*DATA_W-1:0] row_q, row_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           col_q, col_d;
  logic                    ovf_q, ovf_d;
  logic [15:0]             frame_q, frame_d;

  logic                    fifo_full, fifo_empty, fifo_rdy;
  logic                    push, pop;
  logic [DATA_W-1:0]       code, pix_code;
  logic                    tag_sof, tag_eol, tag_eof;
  logic [EW-1:0]           wr_entry, rd_entry;

  assign code = row_q[col_q*DATA_W +: DATA_W];

`ifdef PIXEL_RX_GRAY_DECODE_EN
  assign pix_code = DATA_W'(gray2bin(32'(code)));
`else
  assign pix_code = code;
`endif

  assign tag_sof  = (idx_q == '0) && (col_q == '0);
  assign tag_eol  = (col_q == CW'(N_COLS - 1));
  assign tag_eof  = tag_eol && (idx_q == IW'(N_ROWS - 1));
  assign wr_entry = {pix_code, tag_sof, tag_eol, tag_eof};

  assign rx_busy   = (state_q == SER);
  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  // A pop in the same cycle frees the slot, so a full FIFO need not stall then.
  assign fifo_rdy  = !fifo_full || pop;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    idx_d   = idx_q;
    col_d   = col_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (row_valid) begin
          row_d   = row_data;
          idx_d   = row_idx;
          col_d   = '0;
          state_d = SER;
        end
      end
      SER: begin
        if (fifo_rdy) begin
          push = 1'b1;
          if (tag_eol) state_d = IDLE;
          else         col_d   = col_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Overflow set takes priority over a simultaneous clear.
  assign ovf_d   = (row_valid && rx_busy) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  assign frame_d = (pop && rd_entry[0]) ? frame_q + 16'd1 : frame_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      ovf_q   <= ovf_d;
      frame_q <= frame_d;
    end
  end

  pixel_rx_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .dat_i   (wr_entry),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dat_o   (rd_entry)
  );

  assign pix_data  = rd_entry[EW-1:3];
  assign pix_sof   = rd_entry[2];
  assign pix_eol   = rd_entry[1];
  assign pix_eof   = rd_entry[0];
  assign frame_cnt = frame_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_pixel_readout_rx.sv
// Directed bench for pixel_readout_rx: a depth-4 instance for the main stream and a depth-2 instance for stalls.
module tb_pixel_readout_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        row_valid = 1'b0;
  logic        row_idx = 1'b0;
  logic [15:0] row_data = '0;
  logic        clr_ovf = 1'b0;
  logic        pix_ready = 1'b0;
  logic        rx_busy, pix_valid, pix_sof, pix_eol, pix_eof, ovf_err;
  logic [7:0]  pix_data;
  logic [15:0] frame_cnt;

  logic        rv2 = 1'b0;
  logic        pr2 = 1'b0;
  logic        busy2, pv2, sof2, eol2, eof2, ovf2;
  logic [7:0]  pd2;
  logic [15:0] fc2;

  always #5 clk = ~clk;

  pixel_readout_rx #(.N_ROWS(2), .N_COLS(2), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .row_valid(row_valid), .row_idx(row_idx), .row_data(row_data),
    .rx_busy(rx_busy), .clr_ovf(clr_ovf), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .frame_cnt(frame_cnt), .ovf_err(ovf_err)
  );

  pixel_readout_rx #(.N_ROWS(2), .N_COLS(2), .DATA_W(8), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .row_valid(rv2), .row_idx(row_idx), .row_data(row_data),
    .rx_busy(busy2), .clr_ovf(clr_ovf), .pix_valid(pv2), .pix_ready(pr2),
    .pix_data(pd2), .pix_sof(sof2), .pix_eol(eol2), .pix_eof(eof2),
    .frame_cnt(fc2), .ovf_err(ovf2)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  typedef struct packed {
    logic       idx;
    logic [15:0] row;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sof0;
    logic       eof1;
  } rec_t;

  pix_t got[$];
  pix_t got2[$];
  int   total = 0;
  int   bad = 0;

  always @(negedge clk) begin
    if (!reset && pix_valid && pix_ready) got.push_back({pix_data, pix_sof, pix_eol, pix_eof});
    if (!reset && pv2 && pr2) got2.push_back({pd2, sof2, eol2, eof2});
  end

  function automatic logic [7:0] exp_code(input logic [7:0] x);
    logic [7:0] b;
`ifdef PIXEL_RX_GRAY_DECODE_EN
    for (int i = 0; i < 8; i++) b[i] = ^(x >> i);
`else
    b = x;
`endif
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    got.delete();
    got2.delete();
  endtask

  task automatic send_row(input logic idx, input logic [15:0] d);
    int n = 0;
    while (rx_busy && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("busy_timeout", 32'(rx_busy), 32'd0);
    row_idx   = idx;
    row_data  = d;
    row_valid = 1'b1;
    step();
    row_valid = 1'b0;
  endtask

  task automatic wait_got(input string nm, input int n);
    int k = 0;
    while (got.size() < n && k < 200) begin
      step();
      k++;
    end
    step(5);
    chk(nm, 32'(got.size()), 32'(n));
  endtask

  task automatic chk_pix(input string nm, input int i, input logic [7:0] d,
                         input logic sof, input logic eol, input logic eof);
    if (i < got.size()) begin
      chk({nm, "_data"}, 32'(got[i].d), 32'(d));
      chk({nm, "_tags"}, 32'({got[i].sof, got[i].eol, got[i].eof}), 32'({sof, eol, eof}));
    end else begin
      chk({nm, "_missing"}, 32'(got.size()), 32'(i + 1));
    end
  endtask

  rec_t recs[5];

  initial begin
    recs[0] = '{idx: 1'b0, row: 16'h2211, d0: 8'h11, d1: 8'h22, sof0: 1'b1, eof1: 1'b0};
    recs[1] = '{idx: 1'b1, row: 16'h4433, d0: 8'h33, d1: 8'h44, sof0: 1'b0, eof1: 1'b1};
    recs[2] = '{idx: 1'b1, row: 16'hA5F0, d0: 8'hF0, d1: 8'hA5, sof0: 1'b0, eof1: 1'b1};
    recs[3] = '{idx: 1'b0, row: 16'h0102, d0: 8'h02, d1: 8'h01, sof0: 1'b1, eof1: 1'b0};
    recs[4] = '{idx: 1'b1, row: 16'hFF00, d0: 8'h00, d1: 8'hFF, sof0: 1'b0, eof1: 1'b1};

    // Reset state
    step(2);
    chk("rst_busy", 32'(rx_busy), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_data_tags", 32'({pix_data, pix_sof, pix_eol, pix_eof}), 0);
    chk("rst_frame", 32'(frame_cnt), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    reset = 1'b0;
    got.delete();
    got2.delete();

    // Table-driven rows, free-flowing stream; first two rows form the basic frame
    pix_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_row(recs[i].idx, recs[i].row);
      if (i == 1) begin
        wait_got("t1_cnt", 4);
        chk("t1_frame", 32'(frame_cnt), 1);
      end
    end
    wait_got("tbl_cnt", 10);
    for (int i = 0; i < 5; i++) begin
      chk_pix($sformatf("tbl%0d_c0", i), 2*i,   exp_code(recs[i].d0), recs[i].sof0, 1'b0, 1'b0);
      chk_pix($sformatf("tbl%0d_c1", i), 2*i+1, exp_code(recs[i].d1), 1'b0, 1'b1, recs[i].eof1);
    end
    chk("tbl_frame", 32'(frame_cnt), 3);

    // Backpressure: head pixel held stable
    do_reset();
    pix_ready = 1'b0;
    send_row(1'b0, 16'h2211);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(pix_valid), 1);
      chk("bp_head", 32'({pix_data, pix_sof}), 32'({exp_code(8'h11), 1'b1}));
      step();
    end
    pix_ready = 1'b1;
    wait_got("bp_cnt", 2);
    chk_pix("bp_p0", 0, exp_code(8'h11), 1'b1, 1'b0, 1'b0);
    chk_pix("bp_p1", 1, exp_code(8'h22), 1'b0, 1'b1, 1'b0);

    // Overflow: strobe while busy drops the row
    do_reset();
    pix_ready = 1'b1;
    send_row(1'b0, 16'h2211);
    row_idx = 1'b1; row_data = 16'h4433; row_valid = 1'b1;
    step();
    row_valid = 1'b0;
    chk("ovf_set", 32'(ovf_err), 1);
    wait_got("ovf_cnt", 2);
    chk_pix("ovf_p1", 1, exp_code(8'h22), 1'b0, 1'b1, 1'b0);
    chk("ovf_frame", 32'(frame_cnt), 0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(ovf_err), 0);
    send_row(1'b0, 16'h2211);
    row_valid = 1'b1; clr_ovf = 1'b1;
    step();
    row_valid = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set_wins", 32'(ovf_err), 1);

    // Depth-2 instance: FSM stalls in SER with a full FIFO
    do_reset();
    pix_ready = 1'b0;
    row_idx = 1'b0; row_data = 16'h2211; rv2 = 1'b1;
    step();
    rv2 = 1'b0;
    for (int k = 0; k < 50 && busy2; k++) step();
    row_idx = 1'b1; row_data = 16'h4433; rv2 = 1'b1;
    step();
    rv2 = 1'b0;
    step(5);
    chk("stall_busy", 32'(busy2), 1);
    chk("stall_head", 32'({pv2, pd2}), 32'({1'b1, exp_code(8'h11)}));
    pr2 = 1'b1;
    for (int k = 0; k < 200 && got2.size() < 4; k++) step();
    step(5);
    chk("stall_cnt", 32'(got2.size()), 4);
    if (got2.size() == 4) begin
      chk("stall_d0", 32'(got2[0].d), 32'(exp_code(8'h11)));
      chk("stall_d1", 32'(got2[1].d), 32'(exp_code(8'h22)));
      chk("stall_d2", 32'(got2[2].d), 32'(exp_code(8'h33)));
      chk("stall_d3", 32'({got2[3].d, got2[3].eol, got2[3].eof}), 32'({exp_code(8'h44), 2'b11}));
    end
    chk("stall_frame", 32'(fc2), 1);
    pr2 = 1'b0;

    // Reset mid-row with entries queued
    do_reset();
    pix_ready = 1'b1;
    send_row(1'b0, 16'h2211);
    send_row(1'b1, 16'h4433);
    wait_got("mr_pre_cnt", 4);
    chk("mr_pre_frame", 32'(frame_cnt), 1);
    pix_ready = 1'b0;
    send_row(1'b0, 16'h2211);
    send_row(1'b1, 16'h4433);
    step();
    chk("mr_busy_valid", 32'({rx_busy, pix_valid}), 32'(2'b11));
    reset = 1'b1;
    step();
    chk("mr_rst_valid", 32'(pix_valid), 0);
    chk("mr_rst_frame", 32'(frame_cnt), 0);
    chk("mr_rst_busy_data", 32'({rx_busy, pix_data}), 0);
    reset = 1'b0;
    got.delete();
    pix_ready = 1'b1;
    send_row(1'b0, 16'h6655);
    send_row(1'b1, 16'h8877);
    wait_got("mr_cnt", 4);
    chk_pix("mr_p0", 0, exp_code(8'h55), 1'b1, 1'b0, 1'b0);
    chk_pix("mr_p1", 1, exp_code(8'h66), 1'b0, 1'b1, 1'b0);
    chk_pix("mr_p2", 2, exp_code(8'h77), 1'b0, 1'b0, 1'b0);
    chk_pix("mr_p3", 3, exp_code(8'h88), 1'b0, 1'b1, 1'b1);
    chk("mr_frame", 32'(frame_cnt), 1);

    // Code decode path
    do_reset();
    send_row(1'b0, 16'h00C0);
    wait_got("gray_cnt", 2);
`ifdef PIXEL_RX_GRAY_DECODE_EN
    chk_pix("gray_p0", 0, 8'h80, 1'b1, 1'b0, 1'b0);
`else
    chk_pix("gray_p0", 0, 8'hC0, 1'b1, 1'b0, 1'b0);
`endif
    chk_pix("gray_p1", 1, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
